simple_fifo_splitter: RTL and testbench

Wide-to-narrow first-word-fall-through FIFO: accepts DATA_IN_WIDTH words, buffers them in a 2**ADDR_WIDTH-deep wide store, and presents them as DATA_IN_WIDTH/DATA_OUT_WIDTH consecutive DATA_OUT_WIDTH slices, lowest slice first. It is the read-side counterpart of the narrow-to-wide FIFO adapter. A word packed by that adapter (first narrow word in the low bits) comes back out here in its original order.

---
 rtl/simple_fifo_splitter.sv | 100 ++++++++++
 tb/tb_simple_fifo_splitter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/simple_fifo_splitter.sv
// Wide-to-narrow FWFT FIFO: buffers wide words and
// hands them out as narrow slices, lowest first.
module simple_fifo_splitter #(
  parameter int DATA_IN_WIDTH  = 128,
  parameter int DATA_OUT_WIDTH = 16,
  parameter int ADDR_WIDTH     = 8,
  parameter int FULL_SLACK     = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      wr_ena,
  input  logic [DATA_IN_WIDTH-1:0]  wr_dat,
  output logic                      wr_full,
  input  logic                      rd_ena,
  output logic [DATA_OUT_WIDTH-1:0] rd_dat,
  output logic                      rd_empty,
  output logic [ADDR_WIDTH:0]       wr_dat_cnt
);

  localparam int R     = DATA_IN_WIDTH / DATA_OUT_WIDTH;
  localparam int IW    = $clog2(R);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int THR_I =
    (FULL_SLACK >= DEPTH) ? 0 : DEPTH - FULL_SLACK;
  localparam logic [ADDR_WIDTH:0] THR =
    THR_I[ADDR_WIDTH:0];
  localparam logic [IW-1:0] LAST = IW'(R - 1);

  logic [DATA_IN_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH:0]      wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]      rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]      cnt;
  logic [DATA_IN_WIDTH-1:0] hold_q, hold_d;
  logic                     hold_vld_q, hold_vld_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic                     last, push, pop;

  logic [R-1:0][DATA_OUT_WIDTH-1:0] slices;

  assign cnt  = wr_ptr_q - rd_ptr_q;
  assign last = (idx_q == LAST);
  // count never exceeds DEPTH, so its MSB alone means truly full
  assign push = wr_ena && !cnt[ADDR_WIDTH];
  assign pop  = (!hold_vld_q || (rd_ena && last))
                && (cnt != '0);

  assign wr_full    = (cnt >= THR);
  assign wr_dat_cnt = cnt;
  assign rd_empty   = !hold_vld_q;
  assign slices     = hold_q;
  assign rd_dat     = slices[idx_q];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    idx_d      = idx_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      hold_d     = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
      hold_vld_d = 1'b1;
      idx_d      = '0;
    end else if (hold_vld_q && rd_ena) begin
      if (last) begin
        hold_vld_d = 1'b0;
        idx_d      = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      idx_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      idx_q      <= idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_dat;
    end
  end

endmodule

// File: tb/tb_simple_fifo_splitter.sv
// Bench for simple_fifo_splitter: slice scoreboard plus
// a store-occupancy model, two FULL_SLACK settings.
module tb_simple_fifo_splitter;

  localparam int DI = 128;
  localparam int DO = 16;
  localparam int AW = 4;
  localparam int R  = DI / DO;
  localparam int D  = 2 ** AW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          wr_ena = 1'b0;
  logic [DI-1:0] wr_dat = '0;
  logic          rd_ena = 1'b0;
  logic          full0, full2, emp0, emp2;
  logic [DO-1:0] dat0, dat2;
  logic [AW:0]   cnt0, cnt2;

  int n_chk = 0;
  int n_fail = 0;

  logic [DO-1:0] exp_q [$];
  int  m_store = 0;
  bit  m_hv = 0;
  int  m_idx = 0;

  always #5 clk = ~clk;

  simple_fifo_splitter #(
    .DATA_IN_WIDTH(DI), .DATA_OUT_WIDTH(DO),
    .ADDR_WIDTH(AW), .FULL_SLACK(0)
  ) dut0 (
    .clk(clk), .rstn(rstn), .wr_ena(wr_ena),
    .wr_dat(wr_dat), .wr_full(full0),
    .rd_ena(rd_ena), .rd_dat(dat0),
    .rd_empty(emp0), .wr_dat_cnt(cnt0)
  );

  simple_fifo_splitter #(
    .DATA_IN_WIDTH(DI), .DATA_OUT_WIDTH(DO),
    .ADDR_WIDTH(AW), .FULL_SLACK(2)
  ) dut2 (
    .clk(clk), .rstn(rstn), .wr_ena(wr_ena),
    .wr_dat(wr_dat), .wr_full(full2),
    .rd_ena(rd_ena), .rd_dat(dat2),
    .rd_empty(emp2), .wr_dat_cnt(cnt2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, got, exp);
    end
  endtask

  task automatic step(input bit rs, input bit wr,
                      input logic [DI-1:0] d,
                      input bit rd);
    bit pop_ok, push_ok;
    logic [DO-1:0] e;
    rstn = rs; wr_ena = wr; wr_dat = d; rd_ena = rd;
    if (!rs) begin
      exp_q.delete();
      m_store = 0; m_hv = 0; m_idx = 0;
    end else begin
      if (rd && m_hv) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rd_dat0", dat0, e);
          chk("rd_dat2", dat2, e);
        end
      end
      pop_ok  = (!m_hv || (rd && m_idx == R-1))
                && m_store > 0;
      push_ok = wr && m_store < D;
      if (rd && m_hv) begin
        if (m_idx == R-1) begin
          m_hv = 0; m_idx = 0;
        end else m_idx++;
      end
      if (pop_ok) begin
        m_hv = 1; m_idx = 0; m_store--;
      end
      if (push_ok) begin
        m_store++;
        for (int i = 0; i < R; i++)
          exp_q.push_back(d[i*DO +: DO]);
      end
    end
    @(posedge clk);
    #1;
    chk("rd_empty0", emp0, !m_hv);
    chk("rd_empty2", emp2, !m_hv);
    chk("cnt0", cnt0, m_store);
    chk("cnt2", cnt2, m_store);
    chk("full0", full0, m_store >= D);
    chk("full2", full2, m_store >= D-2);
  endtask

  function automatic logic [DI-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [DI-1:0] word(int k);
    logic [DI-1:0] w;
    for (int i = 0; i < R; i++)
      w[i*DO +: DO] = DO'(k * 16 + i);
    return w;
  endfunction

  initial begin
    int sent, guard;
    logic [DI-1:0] w0;
    @(posedge clk); #1;
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);
    chk("rst_dat", dat0, 0);
    chk("rst_empty", emp0, 1);
    chk("rst_cnt", cnt0, 0);
    chk("rst_full", full0, 0);

    w0 = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
    step(1, 1, w0, 0);
    chk("lat_n_empty", emp0, 1);
    chk("lat_n_cnt", cnt0, 1);
    step(1, 0, '0, 0);
    chk("lat_n1_empty", emp0, 0);
    chk("lat_n1_cnt", cnt0, 0);
    chk("first_slice", dat0, 16'h0000);
    for (int i = 0; i < R; i++) step(1, 0, '0, 1);
    chk("split_done_empty", emp0, 1);
    chk("split_sb_empty", exp_q.size(), 0);

    for (int k = 1; k <= 3; k++) step(1, 1, word(k), 0);
    chk("b2b_cnt", cnt0, 2);
    for (int i = 0; i < 3*R; i++) begin
      chk("b2b_nobubble", emp0, 0);
      step(1, 0, '0, 1);
    end
    chk("b2b_empty", emp0, 1);

    for (int k = 0; k < D+2; k++) begin
      step(1, 1, word(k + 16), 0);
      if (m_store == D-2) chk("af_rise", full2, 1);
      if (m_store == D-3) chk("af_low", full2, 0);
    end
    chk("ovf_cnt", cnt0, D);
    chk("ovf_full", full0, 1);
    chk("ovf_sb", exp_q.size(), (D+1)*R);
    for (int i = 0; i < (D+1)*R; i++) step(1, 0, '0, 1);
    chk("ovf_drained", emp0, 1);
    chk("ovf_sb_empty", exp_q.size(), 0);

    sent = 0; guard = 0;
    while (sent < 100 && guard < 3000) begin
      bit wr;
      wr = ($urandom_range(0, 3) != 0);
      if (wr && m_store < D) sent++;
      step(1, wr, rnd(), $urandom_range(0, 1) == 1);
      chk("rnd_cnt_max", cnt0 <= D, 1);
      guard++;
    end
    chk("rnd_sent", sent, 100);
    guard = 0;
    while ((exp_q.size() > 0 || m_store > 0) && guard < 2000) begin
      step(1, 0, '0, 1);
      guard++;
    end
    chk("rnd_drained", exp_q.size(), 0);

    for (int k = 0; k < 6; k++) step(1, 1, rnd(), 0);
    for (int i = 0; i < 3; i++) step(1, 0, '0, 1);
    chk("pre_rst_cnt", cnt0, 5);
    step(0, 0, '0, 0);
    chk("mid_rst_empty", emp0, 1);
    chk("mid_rst_dat", dat0, 0);
    chk("mid_rst_cnt", cnt0, 0);
    step(1, 1, word(200), 0);
    step(1, 0, '0, 0);
    for (int i = 0; i < R; i++) step(1, 0, '0, 1);
    chk("post_rst_empty", emp0, 1);
    chk("post_rst_sb", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
